regulation_startup_seq: RTL and testbench



---
 rtl/regulation_pkg.sv | 23 ++
 rtl/regulation_startup_seq_if.sv | 27 ++
 rtl/sync2.sv | 22 ++
 rtl/regulation_startup_seq.sv | 154 +++++++++++++++
 tb/tb_regulation_startup_seq.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/regulation_pkg.sv
// Shared types and constants for the regulation start-up sequencer.
package regulation_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ENABLE = 3'd1,
        ST_SETTLE = 3'd2,
        ST_READY  = 3'd3,
        ST_OFF    = 3'd4,
        ST_FAULT  = 3'd5
    } reg_seq_state_t;

    localparam int unsigned STATE_W           = 3;
    localparam int unsigned TMI_W             = 5;
    localparam int unsigned TMI_SETTLE_BYPASS = 0;
    localparam int unsigned TMI_TIMEOUT_DIS   = 1;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/regulation_startup_seq_if.sv
// Control/status bundle between the power-management side, the loop and the sequencer.
interface regulation_startup_seq_if
    import regulation_pkg::*;
#(
    parameter int unsigned RETRY_W = 2
);
    logic                start;
    logic                stop;
    logic                ok_regulation;
    logic                go_driver;
    logic [TMI_W-1:0]    tmi;
    logic                enable_regulation;
    logic                reg_ready;
    logic                fault;
    logic [RETRY_W-1:0]  retry_cnt;
    logic [STATE_W-1:0]  state;

    modport master (
        output start, stop, ok_regulation, go_driver, tmi,
        input  enable_regulation, reg_ready, fault, retry_cnt, state
    );

    modport slave (
        input  start, stop, ok_regulation, go_driver, tmi,
        output enable_regulation, reg_ready, fault, retry_cnt, state
    );
endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer with synchronous active-high reset.
module sync2 (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;
endmodule

// File: rtl/regulation_startup_seq.sv
// Start-up / supervision sequencer: enables the loop, qualifies regulation-good,
// bounds start-up with timeout and retries, and reports ready/fault.
module regulation_startup_seq
    import regulation_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES  = 64,
    parameter int unsigned TIMEOUT_CYCLES = 4096,
    parameter int unsigned OFF_CYCLES     = 32,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    regulation_startup_seq_if.slave  bus
);
    localparam int unsigned SETTLE_W = cnt_width(SETTLE_CYCLES);
    localparam int unsigned TMO_W    = cnt_width(TIMEOUT_CYCLES);
    localparam int unsigned OFF_W    = cnt_width(OFF_CYCLES);
    localparam int unsigned RETRY_W  = cnt_width(MAX_RETRY + 1);

    localparam logic [SETTLE_W-1:0] SETTLE_LAST = SETTLE_W'(SETTLE_CYCLES - 1);
    localparam logic [TMO_W-1:0]    TMO_LAST    = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [OFF_W-1:0]    OFF_LAST    = OFF_W'(OFF_CYCLES - 1);
    localparam logic [RETRY_W-1:0]  RETRY_MAX   = RETRY_W'(MAX_RETRY);

    logic ok_s;
    logic go_s;

    sync2 u_sync_ok (.clk(clk), .rst(rst), .d(bus.ok_regulation), .q(ok_s));
    sync2 u_sync_go (.clk(clk), .rst(rst), .d(bus.go_driver),     .q(go_s));

    reg_seq_state_t      state_q,  state_d;
    logic [SETTLE_W-1:0] settle_q, settle_d, settle_inc;
    logic [TMO_W-1:0]    tmo_q,    tmo_d;
    logic [OFF_W-1:0]    off_q,    off_d;
    logic [RETRY_W-1:0]  retry_q,  retry_d;
    logic                loss_q,   loss_d;
    logic                rearm_q,  rearm_d;
    logic                en_q,     en_d;
    logic                rdy_q,    rdy_d;
    logic                fault_q,  fault_d;

    logic unused_tmi;
    assign unused_tmi = ^bus.tmi[TMI_W-1:2];

    // Next-state, counters and registered-output values.
    always_comb begin
        state_d    = state_q;
        settle_d   = settle_q;
        tmo_d      = tmo_q;
        off_d      = off_q;
        retry_d    = retry_q;
        loss_d     = 1'b0;
        rearm_d    = 1'b0;
        settle_inc = (settle_q != '1) ? settle_q + 1'b1 : settle_q;

        case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                tmo_d    = '0;
                off_d    = '0;
                retry_d  = '0;
                if (bus.start && !bus.stop) state_d = ST_ENABLE;
            end
            ST_ENABLE: begin
                if (tmo_q != '1) tmo_d = tmo_q + 1'b1;
                if (ok_s) begin
                    state_d  = ST_SETTLE;
                    settle_d = '0;
                end else if (!bus.tmi[TMI_TIMEOUT_DIS] && tmo_q == TMO_LAST) begin
                    state_d = (retry_q < RETRY_MAX) ? ST_OFF : ST_FAULT;
                    off_d   = '0;
                end
            end
            ST_SETTLE: begin
                // Timeout count is kept so repeated glitches cannot extend start-up forever.
                if (!ok_s) begin
                    state_d = ST_ENABLE;
                end else begin
                    settle_d = settle_inc;
                    if (bus.tmi[TMI_SETTLE_BYPASS] || settle_inc >= SETTLE_LAST) state_d = ST_READY;
                end
            end
            ST_READY: begin
                loss_d = !ok_s;
                if (!ok_s && loss_q) state_d = ST_FAULT;
            end
            ST_OFF: begin
                if (off_q >= OFF_LAST) begin
                    state_d = ST_ENABLE;
                    tmo_d   = '0;
                    if (retry_q != '1) retry_d = retry_q + 1'b1;
                end else begin
                    off_d = off_q + 1'b1;
                end
            end
            ST_FAULT: begin
                // Exit needs a stop first, then a fresh start without stop.
                rearm_d = rearm_q | bus.stop;
                if (rearm_q && bus.start && !bus.stop) begin
                    state_d = ST_IDLE;
                    retry_d = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (state_q != ST_FAULT &&
            (bus.stop || (!bus.start && state_q inside {ST_ENABLE, ST_SETTLE, ST_READY}))) begin
            state_d  = ST_IDLE;
            settle_d = '0;
            tmo_d    = '0;
            off_d    = '0;
            retry_d  = '0;
            loss_d   = 1'b0;
        end

        en_d    = state_d inside {ST_ENABLE, ST_SETTLE, ST_READY};
        rdy_d   = (state_d == ST_READY) && go_s;
        fault_d = (state_d == ST_FAULT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            settle_q <= '0;
            tmo_q    <= '0;
            off_q    <= '0;
            retry_q  <= '0;
            loss_q   <= 1'b0;
            rearm_q  <= 1'b0;
            en_q     <= 1'b0;
            rdy_q    <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            settle_q <= settle_d;
            tmo_q    <= tmo_d;
            off_q    <= off_d;
            retry_q  <= retry_d;
            loss_q   <= loss_d;
            rearm_q  <= rearm_d;
            en_q     <= en_d;
            rdy_q    <= rdy_d;
            fault_q  <= fault_d;
        end
    end

    assign bus.enable_regulation = en_q;
    assign bus.reg_ready         = rdy_q;
    assign bus.fault             = fault_q;
    assign bus.retry_cnt         = retry_q;
    assign bus.state             = STATE_W'(state_q);

endmodule

// File: tb/tb_regulation_startup_seq.sv
// Directed scoreboard bench for regulation_startup_seq.
module tb_regulation_startup_seq;

    localparam int unsigned RW = 2;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_ENABLE = 3'd1;
    localparam logic [2:0] S_SETTLE = 3'd2;
    localparam logic [2:0] S_READY  = 3'd3;
    localparam logic [2:0] S_OFF    = 3'd4;
    localparam logic [2:0] S_FAULT  = 3'd5;

    typedef struct packed {
        logic [2:0]    st;
        logic          en;
        logic          rdy;
        logic          flt;
        logic [RW-1:0] rc;
    } obs_t;

    logic clk = 1'b0;
    logic rst;

    regulation_startup_seq_if #(.RETRY_W(RW)) bus ();

    regulation_startup_seq #(
        .SETTLE_CYCLES (8),
        .TIMEOUT_CYCLES(16),
        .OFF_CYCLES    (4),
        .MAX_RETRY     (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    obs_t  exp_q[$];
    string tag_q[$];
    int    tests = 0;
    int    fails = 0;

    // Push an expectation, let n cycles elapse, then pop and compare at the negedge.
    task automatic chk(input int n, input string tag, input logic [2:0] st, input logic en,
                       input logic rdy, input logic flt, input logic [RW-1:0] rc);
        obs_t  got;
        obs_t  exp;
        string t;
        exp_q.push_back({st, en, rdy, flt, rc});
        tag_q.push_back(tag);
        repeat (n) @(negedge clk);
        got = {bus.state, bus.enable_regulation, bus.reg_ready, bus.fault, bus.retry_cnt};
        exp = exp_q.pop_front();
        t   = tag_q.pop_front();
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed st=%0d en=%b rdy=%b flt=%b rc=%0d, expected st=%0d en=%b rdy=%b flt=%b rc=%0d",
                   t, got.st, got.en, got.rdy, got.flt, got.rc, exp.st, exp.en, exp.rdy, exp.flt, exp.rc);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst               = 1'b1;
        bus.start         = 1'b0;
        bus.stop          = 1'b0;
        bus.ok_regulation = 1'b0;
        bus.go_driver     = 1'b0;
        bus.tmi           = 5'b00000;
        repeat (2) @(negedge clk);
        chk(0, "reset", S_IDLE, 0, 0, 0, 0);
        rst = 1'b0;

        // Nominal start: ok rises 10 cycles into ENABLE, ready 2+8 cycles later.
        bus.start = 1'b1; bus.go_driver = 1'b1;
        chk(1, "nom_enable", S_ENABLE, 1, 0, 0, 0);
        chk(9, "nom_enable_wait", S_ENABLE, 1, 0, 0, 0);
        bus.ok_regulation = 1'b1;
        chk(2, "nom_sync_delay", S_ENABLE, 1, 0, 0, 0);
        chk(7, "nom_settle_last", S_SETTLE, 1, 0, 0, 0);
        chk(1, "nom_ready", S_READY, 1, 1, 0, 0);

        // Loss in READY: 1-cycle drop ignored, go_driver tracked, 3-cycle drop faults.
        bus.ok_regulation = 1'b0;
        @(negedge clk);
        bus.ok_regulation = 1'b1;
        chk(5, "ready_glitch_ignored", S_READY, 1, 1, 0, 0);
        bus.go_driver = 1'b0;
        chk(4, "ready_go_low", S_READY, 1, 0, 0, 0);
        bus.go_driver = 1'b1;
        chk(4, "ready_go_high", S_READY, 1, 1, 0, 0);
        bus.ok_regulation = 1'b0;
        chk(3, "ready_loss_pre", S_READY, 1, 1, 0, 0);
        chk(1, "ready_loss_fault", S_FAULT, 0, 0, 1, 0);

        // FAULT exit: stop holds FAULT, then start re-asserted passes through IDLE.
        bus.stop = 1'b1; bus.start = 1'b0;
        chk(1, "fault_stop_hold", S_FAULT, 0, 0, 1, 0);
        bus.stop = 1'b0; bus.start = 1'b1;
        chk(1, "fault_exit_idle", S_IDLE, 0, 0, 0, 0);
        chk(1, "restart_enable", S_ENABLE, 1, 0, 0, 0);
        bus.start = 1'b0;
        chk(1, "start_drop_idle", S_IDLE, 0, 0, 0, 0);

        // Settle glitch: drop ok for one cycle mid-SETTLE.
        bus.start = 1'b1; bus.ok_regulation = 1'b1;
        chk(6, "glitch_settle", S_SETTLE, 1, 0, 0, 0);
        bus.ok_regulation = 1'b0;
        @(negedge clk);
        bus.ok_regulation = 1'b1;
        chk(2, "glitch_back_enable", S_ENABLE, 1, 0, 0, 0);
        chk(7, "glitch_settle_again", S_SETTLE, 1, 0, 0, 0);
        chk(1, "glitch_ready", S_READY, 1, 1, 0, 0);
        bus.start = 1'b0; bus.ok_regulation = 1'b0;
        chk(1, "glitch_start_drop", S_IDLE, 0, 0, 0, 0);
        repeat (3) @(negedge clk);

        // Timeout and retries: three 16-cycle windows with 4-cycle gaps, then FAULT.
        bus.start = 1'b1;
        chk(1,  "to_enable1",     S_ENABLE, 1, 0, 0, 0);
        chk(15, "to_enable1_end", S_ENABLE, 1, 0, 0, 0);
        chk(1,  "to_off1",        S_OFF,    0, 0, 0, 0);
        chk(3,  "to_off1_end",    S_OFF,    0, 0, 0, 0);
        chk(1,  "to_enable2",     S_ENABLE, 1, 0, 0, 1);
        chk(15, "to_enable2_end", S_ENABLE, 1, 0, 0, 1);
        chk(1,  "to_off2",        S_OFF,    0, 0, 0, 1);
        chk(4,  "to_enable3",     S_ENABLE, 1, 0, 0, 2);
        chk(15, "to_enable3_end", S_ENABLE, 1, 0, 0, 2);
        chk(1,  "to_fault",       S_FAULT,  0, 0, 1, 2);

        // Priority: stop in the cycle the final timeout fires.
        bus.stop = 1'b1; bus.start = 1'b0;
        chk(1, "to_fault_hold", S_FAULT, 0, 0, 1, 2);
        bus.stop = 1'b0; bus.start = 1'b1;
        chk(1,  "to_fault_exit",     S_IDLE,   0, 0, 0, 0);
        chk(1,  "prio_enable1",      S_ENABLE, 1, 0, 0, 0);
        chk(55, "prio_enable3_last", S_ENABLE, 1, 0, 0, 2);
        bus.stop = 1'b1;
        chk(1, "prio_stop_wins", S_IDLE, 0, 0, 0, 0);
        bus.stop = 1'b0; bus.start = 1'b0;

        // Test mode: timeout disabled and settle bypassed.
        bus.tmi = 5'b00011; bus.start = 1'b1;
        chk(1,  "tm_enable",     S_ENABLE, 1, 0, 0, 0);
        chk(40, "tm_no_timeout", S_ENABLE, 1, 0, 0, 0);
        bus.ok_regulation = 1'b1;
        chk(3, "tm_settle", S_SETTLE, 1, 0, 0, 0);
        chk(1, "tm_ready",  S_READY,  1, 1, 0, 0);

        // Reset mid-sequence.
        rst = 1'b1;
        chk(1, "rst_mid", S_IDLE, 0, 0, 0, 0);
        bus.start = 1'b0;
        rst = 1'b0;
        chk(2, "rst_release_idle", S_IDLE, 0, 0, 0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
